// File: rtl/burrito_pkg.sv
// Shared definitions for the burrito register-file + ALU datapath:
// opcodes, instruction word layout and register file geometry.
package burrito_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int OP_W     = 4;
  localparam int INSN_W   = 20;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0011;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT = 4'b0111;
  localparam logic [OP_W-1:0] OP_SLL = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRL = 4'b1001;
  localparam logic [OP_W-1:0] OP_NOR = 4'b1100;

  // Instruction word field positions
  localparam int INSN_WE_BIT = 19;
  localparam int INSN_OP_HI  = 18;
  localparam int INSN_OP_LO  = 15;
  localparam int INSN_D1_HI  = 14;
  localparam int INSN_D1_LO  = 10;
  localparam int INSN_D2_HI  = 9;
  localparam int INSN_D2_LO  = 5;
  localparam int INSN_RD_HI  = 4;
  localparam int INSN_RD_LO  = 0;

  // Packed view of the instruction word, MSB first, matching the bit positions above
  typedef struct packed {
    logic              we;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] d1;
    logic [ADDR_W-1:0] d2;
    logic [ADDR_W-1:0] rd;
  } insn_t;

  function automatic insn_t make_insn(input logic we, input logic [OP_W-1:0] op,
                                      input logic [ADDR_W-1:0] d1,
                                      input logic [ADDR_W-1:0] d2,
                                      input logic [ADDR_W-1:0] rd);
    insn_t w;
    w.we = we;
    w.op = op;
    w.d1 = d1;
    w.d2 = d2;
    w.rd = rd;
    return w;
  endfunction

endpackage

// File: rtl/burrito_regfile.sv
// 32-entry register file: two combinational read ports, one synchronous write port,
// reset loads reg[k] = k. Optional hardwired-zero register 0 via BURRITO_R0_ZERO_EN.
module burrito_regfile
  import burrito_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [1:0][ADDR_W-1:0]        raddr,
  output logic [1:0][WIDTH-1:0]         rdata
);

`ifdef BURRITO_R0_ZERO_EN
  localparam bit R0_HARDWIRED = 1'b1;
`else
  localparam bit R0_HARDWIRED = 1'b0;
`endif

  logic [WIDTH-1:0] regs_reg [NUM_REGS];
  logic             write_ok;

  assign write_ok = we && !(R0_HARDWIRED && (waddr == '0));

  // Reset wins over a same-cycle write; the write is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_reg[k] <= WIDTH'(k);
      end
    end else if (write_ok) begin
      regs_reg[waddr] <= wdata;
    end
  end

  // No write bypass: reads always see the pre-edge contents.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
      assign rdata[gi] = (R0_HARDWIRED && (raddr[gi] == '0)) ? '0 : regs_reg[raddr[gi]];
    end
  endgenerate

endmodule

// File: rtl/burrito.sv
// Single-cycle register file + ALU datapath; result optionally written back each edge.
// Build option BURRITO_R0_ZERO_EN makes register 0 read as zero and ignore writes.
module burrito
  import burrito_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WEnable,
  input  logic [OP_W-1:0]   Op,
  input  logic [ADDR_W-1:0] D1,
  input  logic [ADDR_W-1:0] D2,
  input  logic [ADDR_W-1:0] RD,
  output logic [WIDTH-1:0]  Result,
  output logic              Zero
);

  logic [1:0][WIDTH-1:0] rdata;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic [4:0]            shamt;
  logic                  a_lt_b;

  burrito_regfile #(
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (WEnable),
    .waddr (RD),
    .wdata (Result),
    .raddr ({D2, D1}),
    .rdata (rdata)
  );

  assign a      = rdata[0];
  assign b      = rdata[1];
  assign shamt  = b[4:0];
  assign a_lt_b = $signed(a) < $signed(b);

  always_comb begin
    Result = '0;
    case (Op)
      OP_AND:  Result = a & b;
      OP_OR:   Result = a | b;
      OP_ADD:  Result = a + b;
      OP_XOR:  Result = a ^ b;
      OP_SUB:  Result = a - b;
      OP_SLT:  Result = {{(WIDTH-1){1'b0}}, a_lt_b};
      OP_SLL:  Result = a << shamt;
      OP_SRL:  Result = a >> shamt;
      OP_NOR:  Result = ~(a | b);
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: tb/tb_burrito.sv
// Directed + randomized checks of burrito against a behavioural register/ALU model.
// Honours BURRITO_R0_ZERO_EN the same way the design build does.
module tb_burrito;
  import burrito_pkg::*;

`ifdef BURRITO_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        WEnable;
  logic [3:0]  Op;
  logic [4:0]  D1, D2, RD;
  logic [31:0] Result;
  logic        Zero;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [32];

  burrito #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .WEnable (WEnable),
    .Op      (Op),
    .D1      (D1),
    .D2      (D2),
    .RD      (RD),
    .Result  (Result),
    .Zero    (Zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [4:0] adr);
    if (R0Z && adr == 5'd0) return 32'd0;
    return model[adr];
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int unsigned sh;
    sh = y % 32;
    case (op)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return 32'(longint'(x) + longint'(y));
      4'd3:  return x ^ y;
      4'd6:  return 32'(longint'(x) - longint'(y));
      4'd7:  return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      4'd8:  return 32'(longint'(x) * (longint'(1) << sh));
      4'd9:  return x / (32'd1 << sh);
      4'd12: return 32'hFFFF_FFFF ^ (x | y);
      default: return 32'd0;
    endcase
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 32; k++) model[k] = 32'(k);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction: drive after the falling edge, check mid-cycle, then commit to the model.
  task automatic exec(input logic rst_i, input logic we_i, input logic [3:0] op_i,
                      input logic [4:0] d1_i, input logic [4:0] d2_i, input logic [4:0] rd_i,
                      input bit want_en, input logic [31:0] want, input string tag);
    logic [31:0] exp;
    @(negedge clk);
    rst = rst_i; WEnable = we_i; Op = op_i; D1 = d1_i; D2 = d2_i; RD = rd_i;
    #1;
    exp = ref_alu(op_i, rd_model(d1_i), rd_model(d2_i));
    $display("txn %s: rst=%0b we=%0b op=%h d1=%0d d2=%0d rd=%0d result=%h", tag, rst_i, we_i, op_i, d1_i, d2_i, rd_i, Result);
    check({tag, ".result"}, Result, exp);
    check({tag, ".zero"}, {31'd0, Zero}, {31'd0, exp == 32'd0});
    if (want_en) check({tag, ".directed"}, Result, want);
    @(posedge clk);
    if (rst_i) reset_model();
    else if (we_i && !(R0Z && rd_i == 5'd0)) model[rd_i] = exp;
  endtask

  initial begin
    insn_t w;
    rst = 1'b1; WEnable = 1'b0; Op = 4'd0; D1 = 5'd0; D2 = 5'd0; RD = 5'd0;
    repeat (2) @(posedge clk);
    reset_model();
    @(negedge clk);
    rst = 1'b0;

    // Reset pattern: reg[k] | reg[0] == k in both configurations
    for (int k = 0; k < 32; k++)
      exec(0, 0, OP_OR, 5'(k), 5'd0, 5'd0, 1, 32'(k), $sformatf("reset_r%0d", k));

    exec(0, 1, OP_ADD, 5'd3, 5'd4, 5'd10, 1, 32'd7, "add_3_4");
    exec(0, 0, OP_OR, 5'd10, 5'd0, 5'd0, 1, 32'd7, "rd_r10");
    exec(0, 0, OP_SUB, 5'd5, 5'd5, 5'd5, 1, 32'd0, "sub_5_5");
    exec(0, 0, OP_OR, 5'd5, 5'd0, 5'd0, 1, 32'd5, "r5_held");
    exec(0, 0, OP_SLT, 5'd2, 5'd9, 5'd0, 1, 32'd1, "slt_2_9");
    exec(0, 0, OP_SLT, 5'd9, 5'd2, 5'd0, 1, 32'd0, "slt_9_2");
    exec(0, 0, OP_SUB, 5'd2, 5'd9, 5'd0, 1, 32'hFFFF_FFF9, "sub_2_9");
    exec(0, 0, OP_SLL, 5'd3, 5'd2, 5'd0, 1, 32'd12, "sll_3_2");
    exec(0, 0, OP_NOR, 5'd0, 5'd0, 5'd0, 1, 32'hFFFF_FFFF, "nor_0_0");
    exec(0, 1, OP_SUB, 5'd2, 5'd9, 5'd20, 1, 32'hFFFF_FFF9, "sub_wr20");
    exec(0, 0, OP_SLT, 5'd20, 5'd1, 5'd0, 1, 32'd1, "slt_neg");
    exec(0, 0, OP_SRL, 5'd20, 5'd4, 5'd0, 1, 32'h0FFF_FFFF, "srl_neg");
    exec(0, 1, 4'hF, 5'd1, 5'd2, 5'd4, 1, 32'd0, "bad_op_wr4");
    exec(0, 0, OP_OR, 5'd4, 5'd0, 5'd0, 1, 32'd0, "r4_zeroed");
    exec(0, 1, OP_ADD, 5'd6, 5'd6, 5'd6, 1, 32'd12, "self_rw6");
    exec(0, 0, OP_OR, 5'd6, 5'd0, 5'd0, 1, 32'd12, "r6_new");
    exec(1, 1, OP_ADD, 5'd1, 5'd1, 5'd7, 0, 32'd0, "rst_vs_wr");
    exec(0, 0, OP_OR, 5'd7, 5'd0, 5'd0, 1, 32'd7, "r7_reset");
    exec(0, 0, OP_OR, 5'd4, 5'd0, 5'd0, 1, 32'd4, "r4_reset");
    exec(0, 1, OP_ADD, 5'd3, 5'd4, 5'd0, 1, 32'd7, "add_wr_r0");
    exec(0, 0, OP_OR, 5'd0, 5'd0, 5'd0, 1, R0Z ? 32'd0 : 32'd7, "r0_after_wr");

    // Random instruction words, unpacked through the instruction layout
    for (int n = 0; n < 300; n++) begin
      w = insn_t'(20'($urandom_range(0, (1 << INSN_W) - 1)));
      exec(0, w.we, w.op, w.d1, w.d2, w.rd, 0, 32'd0, $sformatf("rnd%0d", n));
    end

    // Sweep every register against the model to catch silent corruption
    for (int k = 0; k < 32; k++)
      exec(0, 0, OP_OR, 5'(k), 5'(k), 5'd0, 0, 32'd0, $sformatf("final_r%0d", k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
